regfile_scoreboard: RTL and testbench

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard_if.sv | 45 ++++
 rtl/regfile_scoreboard.sv | 109 ++++++++++
 tb/tb_regfile_scoreboard.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// Bundles the register file's read, write, issue and scoreboard signals.
// The slave side is the register file; the master side is the pipeline driving it.
interface regfile_scoreboard_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic              rs1_busy;
  logic              rs2_busy;

  logic              wr0_en;
  logic [ADDR_W-1:0] wr0_addr;
  logic [DATA_W-1:0] wr0_data;
  logic              wr1_en;
  logic [ADDR_W-1:0] wr1_addr;
  logic [DATA_W-1:0] wr1_data;

  logic              iss_valid;
  logic [ADDR_W-1:0] iss_rd;
  logic              flush;
  logic [ADDR_W:0]   busy_cnt;

  modport slave (
    input  rs1_addr, rs2_addr,
    output rs1_data, rs2_data, rs1_busy, rs2_busy,
    input  wr0_en, wr0_addr, wr0_data,
    input  wr1_en, wr1_addr, wr1_data,
    input  iss_valid, iss_rd, flush,
    output busy_cnt
  );

  modport master (
    output rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy,
    output wr0_en, wr0_addr, wr0_data,
    output wr1_en, wr1_addr, wr1_data,
    output iss_valid, iss_rd, flush,
    input  busy_cnt
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Two-read/two-write register file with write-to-read bypass and a per-register
// pending-writer scoreboard (RAW hazard detection) with a registered busy count.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic                 clk,
  input  logic                 rst_ni,
  regfile_scoreboard_if.slave  rf
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [ADDR_W:0]     busy_cnt_q;
  logic [ADDR_W:0]     busy_cnt_d;

  logic wr0_hit;
  logic wr1_hit;

  function automatic logic [ADDR_W:0] popcount(input logic [NUM_REGS-1:0] v);
    logic [ADDR_W:0] c;
    c = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      c = c + {{ADDR_W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Port 1 (load writeback) takes priority over port 0 on the bypass path.
  function automatic logic [DATA_W-1:0] read_mux(
    input logic [ADDR_W-1:0] a,
    input logic [DATA_W-1:0] stored,
    input logic              w0_en,
    input logic [ADDR_W-1:0] w0_addr,
    input logic [DATA_W-1:0] w0_data,
    input logic              w1_en,
    input logic [ADDR_W-1:0] w1_addr,
    input logic [DATA_W-1:0] w1_data
  );
    if (a == '0)                      return '0;
    else if (w1_en && w1_addr == a)   return w1_data;
    else if (w0_en && w0_addr == a)   return w0_data;
    else                              return stored;
  endfunction

  // A writer retiring this cycle resolves the hazard for the reader.
  function automatic logic read_busy(
    input logic [ADDR_W-1:0] a,
    input logic              busy_bit,
    input logic              w0_en,
    input logic [ADDR_W-1:0] w0_addr,
    input logic              w1_en,
    input logic [ADDR_W-1:0] w1_addr
  );
    return (a != '0) && busy_bit &&
           !(w0_en && w0_addr == a) && !(w1_en && w1_addr == a);
  endfunction

  assign wr0_hit = rf.wr0_en && (rf.wr0_addr != '0);
  assign wr1_hit = rf.wr1_en && (rf.wr1_addr != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr0_hit) regs_d[rf.wr0_addr] = rf.wr0_data;
    if (wr1_hit) regs_d[rf.wr1_addr] = rf.wr1_data;
    regs_d[0] = '0;
  end

  // Clears first, then issue, then flush: later assignments take precedence.
  always_comb begin
    busy_d = busy_q;
    if (wr0_hit) busy_d[rf.wr0_addr] = 1'b0;
    if (wr1_hit) busy_d[rf.wr1_addr] = 1'b0;
    if (rf.iss_valid && rf.iss_rd != '0) busy_d[rf.iss_rd] = 1'b1;
    if (rf.flush) busy_d = '0;
    busy_d[0] = 1'b0;
    busy_cnt_d = popcount(busy_d);
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign rf.rs1_data = read_mux(rf.rs1_addr, regs_q[rf.rs1_addr],
                                rf.wr0_en, rf.wr0_addr, rf.wr0_data,
                                rf.wr1_en, rf.wr1_addr, rf.wr1_data);
  assign rf.rs2_data = read_mux(rf.rs2_addr, regs_q[rf.rs2_addr],
                                rf.wr0_en, rf.wr0_addr, rf.wr0_data,
                                rf.wr1_en, rf.wr1_addr, rf.wr1_data);
  assign rf.rs1_busy = read_busy(rf.rs1_addr, busy_q[rf.rs1_addr],
                                 rf.wr0_en, rf.wr0_addr, rf.wr1_en, rf.wr1_addr);
  assign rf.rs2_busy = read_busy(rf.rs2_addr, busy_q[rf.rs2_addr],
                                 rf.wr0_en, rf.wr0_addr, rf.wr1_en, rf.wr1_addr);
  assign rf.busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: behavioural model feeds an
// expected-value queue that is drained as the DUT outputs are sampled.
module tb_regfile_scoreboard;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;

  logic clk    = 1'b0;
  logic rst_ni = 1'b0;

  always #5 clk = ~clk;

  regfile_scoreboard_if #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) rf ();

  regfile_scoreboard #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
    .clk    (clk),
    .rst_ni (rst_ni),
    .rf     (rf)
  );

  typedef struct {
    string             tag;
    logic [DATA_W-1:0] val;
  } exp_t;

  exp_t                sb_q[$];
  logic [DATA_W-1:0]   m_regs [NUM_REGS];
  logic [NUM_REGS-1:0] m_busy;
  int                  n_cmp = 0;
  int                  n_err = 0;

  task automatic check_val(input string tag, input logic [DATA_W-1:0] got,
                           input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] observe(input string tag);
    case (tag)
      "rs1_data": return rf.rs1_data;
      "rs2_data": return rf.rs2_data;
      "rs1_busy": return {{(DATA_W-1){1'b0}}, rf.rs1_busy};
      "rs2_busy": return {{(DATA_W-1){1'b0}}, rf.rs2_busy};
      "busy_cnt": return {{(DATA_W-ADDR_W-1){1'b0}}, rf.busy_cnt};
      default:    return 'x;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] model_data(input logic [ADDR_W-1:0] a);
    if (a == 0) return '0;
    if (rf.wr1_en && rf.wr1_addr == a) return rf.wr1_data;
    if (rf.wr0_en && rf.wr0_addr == a) return rf.wr0_data;
    return m_regs[a];
  endfunction

  function automatic logic model_busy(input logic [ADDR_W-1:0] a);
    if (a == 0) return 1'b0;
    if (rf.wr0_en && rf.wr0_addr == a) return 1'b0;
    if (rf.wr1_en && rf.wr1_addr == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic push(input string tag, input logic [DATA_W-1:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      if (sb_q.size() == 0) begin
        check_val("sb_empty", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check_val(e.tag, observe(e.tag), e.val);
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
    m_busy = '0;
  endtask

  task automatic model_edge();
    if (rst_ni) begin
      if (rf.wr0_en && rf.wr0_addr != 0) m_regs[rf.wr0_addr] = rf.wr0_data;
      if (rf.wr1_en && rf.wr1_addr != 0) m_regs[rf.wr1_addr] = rf.wr1_data;
      if (rf.flush) begin
        m_busy = '0;
      end else begin
        if (rf.wr0_en) m_busy[rf.wr0_addr] = 1'b0;
        if (rf.wr1_en) m_busy[rf.wr1_addr] = 1'b0;
        if (rf.iss_valid) m_busy[rf.iss_rd] = 1'b1;
      end
      m_busy[0] = 1'b0;
    end
  endtask

  task automatic idle();
    rf.rs1_addr  = '0;
    rf.rs2_addr  = '0;
    rf.wr0_en    = 1'b0;
    rf.wr0_addr  = '0;
    rf.wr0_data  = '0;
    rf.wr1_en    = 1'b0;
    rf.wr1_addr  = '0;
    rf.wr1_data  = '0;
    rf.iss_valid = 1'b0;
    rf.iss_rd    = '0;
    rf.flush     = 1'b0;
  endtask

  // Inputs are set 1 time unit after a rising edge; sampling happens mid-cycle.
  task automatic cycle();
    push("rs1_data", model_data(rf.rs1_addr));
    push("rs1_busy", {{(DATA_W-1){1'b0}}, model_busy(rf.rs1_addr)});
    push("rs2_data", model_data(rf.rs2_addr));
    push("rs2_busy", {{(DATA_W-1){1'b0}}, model_busy(rf.rs2_addr)});
    #2;
    pop_check(4);
    model_edge();
    push("busy_cnt", DATA_W'($countones(m_busy)));
    @(posedge clk);
    #1;
    pop_check(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    idle();
    rf.rs1_addr = 5'd3;
    #2;
    check_val("reset_cnt", observe("busy_cnt"), 0);
    check_val("reset_rs1", rf.rs1_data, 0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;

    // Port 0 write, then read back
    idle(); rf.wr0_en = 1; rf.wr0_addr = 5; rf.wr0_data = 32'hDEADBEEF; rf.rs1_addr = 5;
    cycle();
    idle(); rf.rs1_addr = 5;
    cycle();
    check_val("x5_read", rf.rs1_data, 32'hDEADBEEF);
    check_val("x5_busy", observe("rs1_busy"), 0);

    // Dual write same address: port 1 wins
    idle(); rf.wr0_en = 1; rf.wr0_addr = 7; rf.wr0_data = 32'h11;
    rf.wr1_en = 1; rf.wr1_addr = 7; rf.wr1_data = 32'h22; rf.rs2_addr = 7;
    cycle();
    idle(); rf.rs2_addr = 7;
    cycle();
    check_val("x7_port1_wins", rf.rs2_data, 32'h22);

    // Enables off: address match must not bypass
    idle(); rf.wr0_addr = 7; rf.wr0_data = 32'h99; rf.wr1_addr = 7; rf.wr1_data = 32'h98;
    rf.rs1_addr = 7;
    cycle();

    // Register zero ignores writes and issues
    idle(); rf.wr0_en = 1; rf.wr0_addr = 0; rf.wr0_data = 32'hFFFFFFFF;
    rf.iss_valid = 1; rf.iss_rd = 0; rf.rs1_addr = 0;
    cycle();
    check_val("x0_cnt", observe("busy_cnt"), 0);

    // Issue x3, x4; retire x3 while reissuing it
    idle(); rf.iss_valid = 1; rf.iss_rd = 3;
    cycle();
    idle(); rf.iss_valid = 1; rf.iss_rd = 4; rf.rs1_addr = 3;
    cycle();
    check_val("iss_cnt2", observe("busy_cnt"), 2);
    idle(); rf.wr1_en = 1; rf.wr1_addr = 3; rf.wr1_data = 32'h55;
    rf.iss_valid = 1; rf.iss_rd = 3; rf.rs1_addr = 3;
    cycle();
    check_val("set_wins_cnt", observe("busy_cnt"), 2);
    idle(); rf.rs1_addr = 3;
    cycle();
    check_val("x3_still_busy", observe("rs1_busy"), 1);

    // Flush overrides a same-cycle issue
    idle(); rf.iss_valid = 1; rf.iss_rd = 9;
    cycle();
    idle(); rf.iss_valid = 1; rf.iss_rd = 10;
    cycle();
    idle(); rf.flush = 1; rf.iss_valid = 1; rf.iss_rd = 11;
    cycle();
    check_val("flush_cnt", observe("busy_cnt"), 0);
    idle(); rf.rs1_addr = 9; rf.rs2_addr = 11;
    cycle();

    // Asynchronous reset mid-operation
    idle(); rf.wr0_en = 1; rf.wr0_addr = 12; rf.wr0_data = 32'hA5A5A5A5;
    cycle();
    idle(); rf.iss_valid = 1; rf.iss_rd = 12;
    cycle();
    rst_ni = 1'b0;
    model_reset();
    idle(); rf.rs1_addr = 12;
    #1;
    check_val("rst_async_cnt", observe("busy_cnt"), 0);
    check_val("rst_async_x12", rf.rs1_data, 0);
    idle(); rf.wr0_en = 1; rf.wr0_addr = 12; rf.wr0_data = 32'h77;
    rf.iss_valid = 1; rf.iss_rd = 13; rf.rs1_addr = 12;
    cycle();
    rst_ni = 1'b1;
    idle(); rf.rs1_addr = 12;
    cycle();

    // Random traffic over a small address window to force collisions
    for (int i = 0; i < 40; i++) begin
      idle();
      rf.wr0_en    = 1'($urandom_range(0, 1));
      rf.wr0_addr  = ADDR_W'($urandom_range(0, 7));
      rf.wr0_data  = $urandom;
      rf.wr1_en    = 1'($urandom_range(0, 1));
      rf.wr1_addr  = ADDR_W'($urandom_range(0, 7));
      rf.wr1_data  = $urandom;
      rf.iss_valid = 1'($urandom_range(0, 1));
      rf.iss_rd    = ADDR_W'($urandom_range(0, 7));
      rf.flush     = ($urandom_range(0, 7) == 0);
      rf.rs1_addr  = ADDR_W'($urandom_range(0, 7));
      rf.rs2_addr  = ADDR_W'($urandom_range(0, 7));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
